// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32x32 word memory.
// Each granted access runs IDLE -> ACCESS -> CAPTURE -> ACK (one access per
// four cycles). Optional build macro MEM_ARB_CLEAR_EN adds a post-reset CLEAR
// sequence that writes zero to every word while holding busy high.
module mem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic [4:0]  mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [31:0] mem_data_out,
   output logic        busy
);

   // state   | meaning
   // IDLE    | wait for a request, pick a winner, latch its command
   // ACCESS  | exactly one memory enable high for the latched command
   // CAPTURE | read data valid on mem_data_out, loaded into winner's rdata
   // ACK     | one-cycle ack to the winner, last-grant pointer updated
   // CLEAR   | (MEM_ARB_CLEAR_EN only) zero-fill addresses 0..31, busy high
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      CAPTURE = 3'd2,
      ACK     = 3'd3
`ifdef MEM_ARB_CLEAR_EN
      ,CLEAR  = 3'd4
`endif
   } state_t;

`ifdef MEM_ARB_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t state;
   logic   lat_we;
   logic   gnt_b;
   logic   last_b;
   logic   pick_b;

   // B wins when it is the only requester, or both request and A went last.
   assign pick_b = b_req & (~a_req | ~last_b);

`ifdef MEM_ARB_CLEAR_EN
   logic busy_q;
   assign busy = busy_q;
`else
   assign busy = 1'b0;
`endif

   // Arbitration FSM with registered memory and requester outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= RESET_STATE;
         lat_we       <= 1'b0;
         gnt_b        <= 1'b0;
         last_b       <= 1'b1;
         a_ack        <= 1'b0;
         b_ack        <= 1'b0;
         a_rdata      <= '0;
         b_rdata      <= '0;
         mem_address  <= '0;
         mem_data_in  <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
`ifdef MEM_ARB_CLEAR_EN
         busy_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  gnt_b        <= pick_b;
                  lat_we       <= pick_b ? b_we : a_we;
                  mem_address  <= pick_b ? b_addr : a_addr;
                  mem_data_in  <= pick_b ? b_wdata : a_wdata;
                  mem_write_en <= pick_b ? b_we : a_we;
                  mem_read_en  <= pick_b ? ~b_we : ~a_we;
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               mem_write_en <= 1'b0;
               mem_read_en  <= 1'b0;
               state        <= CAPTURE;
            end
            CAPTURE: begin
               if (!lat_we) begin
                  if (gnt_b) b_rdata <= mem_data_out;
                  else       a_rdata <= mem_data_out;
               end
               a_ack <= ~gnt_b;
               b_ack <= gnt_b;
               state <= ACK;
            end
            ACK: begin
               a_ack  <= 1'b0;
               b_ack  <= 1'b0;
               last_b <= gnt_b;
               state  <= IDLE;
            end
`ifdef MEM_ARB_CLEAR_EN
            CLEAR: begin
               busy_q      <= 1'b1;
               mem_data_in <= '0;
               if (!mem_write_en) begin
                  mem_write_en <= 1'b1;
                  mem_address  <= '0;
               end else if (mem_address == 5'd31) begin
                  mem_write_en <= 1'b0;
                  mem_address  <= '0;
                  busy_q       <= 1'b0;
                  state        <= IDLE;
               end else begin
                  mem_address <= mem_address + 5'd1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single-requester accesses, hand-written
// round-robin, early-drop, and mid-access reset sequences, with a queue
// scoreboard consumed by an ack monitor.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        a_ack, b_ack, mem_read_en, mem_write_en, busy;
   logic [31:0] a_rdata, b_rdata, mem_data_in;
   logic [31:0] mem_data_out = '0;
   logic [4:0]  mem_address;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   always #5 clock = ~clock;

   // Memory model: synchronous write, read data valid the cycle after read_en.
   logic [31:0] tb_mem [32];
   initial for (int i = 0; i < 32; i++) tb_mem[i] = '0;
   always @(posedge clock) begin
      if (mem_write_en) tb_mem[mem_address] <= mem_data_in;
      if (mem_read_en)  mem_data_out <= tb_mem[mem_address];
   end

   typedef struct {
      bit          who;
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      bit          who;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_a = '0, model_b = '0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] post_reset(input logic [31:0] v);
`ifdef MEM_ARB_CLEAR_EN
      return 32'h0;
`else
      return v;
`endif
   endfunction

   // Ack monitor: pops the scoreboard and checks owner plus both rdata ports.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         if (a_ack && b_ack) begin
            miscompares++;
            $display("FAIL dual_ack: got a_ack=1 b_ack=1 expected one-hot at %0t", $time);
         end
         if (mem_read_en && mem_write_en) begin
            miscompares++;
            $display("FAIL dual_en: got read_en=1 write_en=1 expected exclusive at %0t", $time);
         end
         if (a_ack || b_ack) begin
            if (sbq.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_ack: got a_ack=%0b b_ack=%0b expected none at %0t", a_ack, b_ack, $time);
            end else begin
               e = sbq.pop_front();
               check32("ack_owner", {31'b0, b_ack}, {31'b0, e.who});
               if (e.rd) begin
                  if (e.who) model_b = e.data;
                  else       model_a = e.data;
               end
               check32("a_rdata", a_rdata, model_a);
               check32("b_rdata", b_rdata, model_b);
            end
         end
      end
   end

   task automatic drive(input bit who, input bit we, input logic [4:0] addr, input logic [31:0] wdata);
      if (who) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
      else     begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (busy && n < 100) begin @(posedge clock); #1; n++; end
      if (busy) check32("busy_timeout", {31'b0, busy}, 32'h0);
   endtask

   // One access; glitch drops own req after latching and pulses the other req.
   task automatic txn(input bit who, input bit we, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input bit glitch);
      int n = 0;
      bit got = 0;
      @(posedge clock); #1;
      sbq.push_back('{who, !we, rdata});
      drive(who, we, addr, wdata);
      while (n < 10 && !got) begin
         @(posedge clock); n++;
         if (glitch && n == 1) begin
            #1;
            if (who) begin b_req = 1'b0; a_req = 1'b1; end
            else     begin a_req = 1'b0; b_req = 1'b1; end
         end
         if (glitch && n == 2) begin #1; a_req = 1'b0; b_req = 1'b0; end
         @(negedge clock);
         got = who ? b_ack : a_ack;
      end
      check32("latency", 32'(n + 1), 32'd4);
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic check_reset_values();
      check32("rst_ack", {30'b0, a_ack, b_ack}, 32'h0);
      check32("rst_en", {30'b0, mem_read_en, mem_write_en}, 32'h0);
      check32("rst_addr", {27'b0, mem_address}, 32'h0);
      check32("rst_wdata", mem_data_in, 32'h0);
      check32("rst_a_rdata", a_rdata, 32'h0);
      check32("rst_b_rdata", b_rdata, 32'h0);
      check32("rst_busy", {31'b0, busy}, 32'h0);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      #1;
      check_reset_values();
      model_a = '0;
      model_b = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      wait_ready();
   endtask

   vec_t vecs [8];

   initial begin
      int cnt;
      int n;
      vecs[0] = '{0, 1, 5'd5,  32'hDEADBEEF, 32'h0};
      vecs[1] = '{0, 0, 5'd5,  32'h0,        32'hDEADBEEF};
      vecs[2] = '{1, 1, 5'd31, 32'h12345678, 32'h0};
      vecs[3] = '{0, 0, 5'd31, 32'h0,        32'h12345678};
      vecs[4] = '{1, 0, 5'd5,  32'h0,        32'hDEADBEEF};
      vecs[5] = '{0, 1, 5'd0,  32'hA5A5A5A5, 32'h0};
      vecs[6] = '{1, 0, 5'd0,  32'h0,        32'hA5A5A5A5};
      vecs[7] = '{0, 0, 5'd0,  32'h0,        32'hA5A5A5A5};

      #1;
      check_reset_values();
      @(negedge clock);
      reset = 1'b1;
      wait_ready();

      for (int i = 0; i < 8; i++)
         txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b0);

      // A drops req after latching; B glitches while A is granted.
      txn(1'b0, 1'b0, 5'd31, 32'h0, 32'h12345678, 1'b1);

      // Fresh reset: A must win first, then strict alternation.
      do_reset();
      @(posedge clock); #1;
      sbq.push_back('{0, 1, post_reset(32'hDEADBEEF)});
      sbq.push_back('{1, 1, post_reset(32'h12345678)});
      sbq.push_back('{0, 1, post_reset(32'hDEADBEEF)});
      sbq.push_back('{1, 1, post_reset(32'h12345678)});
      drive(1'b0, 1'b0, 5'd5, 32'h0);
      drive(1'b1, 1'b0, 5'd31, 32'h0);
      cnt = 0;
      n = 0;
      while (cnt < 4 && n < 40) begin
         @(negedge clock); n++;
         if (a_ack || b_ack) cnt++;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check32("rr_acks", 32'(cnt), 32'd4);

      // Reset during the ACCESS cycle of a write abandons it.
      @(posedge clock); @(posedge clock); #1;
      drive(1'b0, 1'b1, 5'd5, 32'hCAFEF00D);
      @(posedge clock); #1;
      check32("access_we", {31'b0, mem_write_en}, 32'h1);
      reset = 1'b0;
      a_req = 1'b0;
      #1;
      check32("abort_en", {30'b0, mem_read_en, mem_write_en}, 32'h0);
      check32("abort_ack", {30'b0, a_ack, b_ack}, 32'h0);
      model_a = '0;
      model_b = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      wait_ready();
      txn(1'b0, 1'b0, 5'd5, 32'h0, post_reset(32'hDEADBEEF), 1'b0);

      repeat (5) @(posedge clock);
      check32("sb_empty", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-008, with clock and reset first.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it forces the reset state immediately, and release is sampled on clock.
REQ-004 a_req / b_req  input  1  per-requester access request; held high until the matching ack.
REQ-005 a_we, a_addr[4:0], a_wdata[31:0] / b_we, b_addr[4:0], b_wdata[31:0]  input  -  per-requester command: 1 = write, 0 = read; word address; write data.
REQ-006 a_ack / b_ack  output  1  one-cycle completion pulse; a_rdata[31:0] / b_rdata[31:0] output 32 carry read data, held until that requester's next read completes.
REQ-007 mem_address[4:0], mem_data_in[31:0], mem_read_en, mem_write_en  output  -  drive the shared 32x32 word memory; mem_data_out[31:0] input 32 returns the memory read data.
REQ-008 busy  output  1  high while a clear sequence runs (see REQ-025 and REQ-026).

Function
REQ-009 FSM states SHALL be IDLE, ACCESS, CAPTURE and ACK, plus CLEAR when the macro in REQ-025 is defined.
REQ-010 IDLE: when either req is sampled high, the FSM SHALL pick a winner, latch its we, addr and wdata into internal registers, record the grant, and go to ACCESS; with no req it stays in IDLE.
REQ-011 Arbitration SHALL be round-robin: if both requests are high, grant the requester not granted last; after reset, A has priority.
REQ-012 ACCESS: the FSM SHALL drive mem_address and mem_data_in from the latched registers and assert exactly one of mem_write_en or mem_read_en for exactly one cycle, then go to CAPTURE.
REQ-013 Memory contract: read data is valid on mem_data_out in the cycle after the mem_read_en cycle.
REQ-014 CAPTURE: for a read, the FSM SHALL load mem_data_out into the granted requester's rdata register on this edge; for a write, no rdata register changes. It then goes to ACK.
REQ-015 ACK: the FSM SHALL assert the granted requester's ack for exactly this cycle, update the last-grant pointer, and return to IDLE.
REQ-016 Latency SHALL be 4 cycles from the IDLE sampling edge to the ack-high cycle; throughput is one access per 4 cycles.
REQ-017 A requester SHALL deassert req in the cycle after its ack; if req is still high in IDLE, it is treated as a new request.
REQ-018 A req that drops after being latched SHALL NOT abort the transaction; the ack still pulses.
REQ-019 A req that changes while the other requester is granted SHALL have no effect until IDLE.
REQ-020 mem_read_en and mem_write_en SHALL never be high at the same time; both SHALL be 0 outside ACCESS and CLEAR.
REQ-021 a_ack and b_ack SHALL never be high at the same time.

Reset
REQ-022 While reset=0: FSM in IDLE (or CLEAR, see REQ-025), all ack, mem_*_en and busy outputs 0, mem_address=0, mem_data_in=0, both rdata registers=0, last-grant pointer points to B (so A wins first).
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no ack and no further memory enable.
REQ-024 Memory contents are not cleared by this block's reset unless the macro in REQ-025 is defined.

Configuration
REQ-025 With MEM_ARB_CLEAR_EN defined: after reset release the FSM SHALL enter CLEAR, write 0 to addresses 0 through 31 in order, one per cycle (mem_write_en high for 32 consecutive cycles), hold busy=1 and ignore all requests, then go to IDLE.
REQ-026 Without MEM_ARB_CLEAR_EN: CLEAR SHALL not exist, the FSM SHALL leave reset in IDLE, and busy SHALL be tied to 0.

Verification
REQ-027 A writes 0xDEADBEEF to address 5, then A reads address 5 -> a_ack pulses 4 cycles after each request, and a_rdata=0xDEADBEEF.
REQ-028 A and B request in the same cycle, both held -> A acked first, then B; with both requests repeated continuously the grants alternate A, B, A, B.
REQ-029 B writes 0x12345678 to address 31, then A reads address 31 -> a_rdata=0x12345678, and b_rdata is unchanged.
REQ-030 reset pulled low during the ACCESS cycle of a write -> no ack, all enables 0 immediately; after release the next read returns the prior contents (or 0 when MEM_ARB_CLEAR_EN is defined).
REQ-031 With MEM_ARB_CLEAR_EN defined: reset released while a_req is high -> busy stays high for 32 cycles with addresses 0 to 31 written with 0, then A is served; a read of address 7 returns 0x00000000.
